// File: rtl/key_target_decoder_pkg.sv
// Shared constants for the battleship key/target decoder: game-state codes,
// PS/2 set-2 control bytes, parser state encoding and board size.
package key_target_decoder_pkg;

    localparam int CELLS = 36;

    // Game-state codes driven by the top-level controller
    localparam logic [2:0] ST_PLACE = 3'd1;
    localparam logic [2:0] ST_FIRE  = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;

    // PS/2 set-2 prefix and control make codes
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;

    // Scan-code parser states
    typedef enum logic [1:0] {
        P_IDLE    = 2'd0,
        P_BRK     = 2'd1,
        P_EXT     = 2'd2,
        P_EXT_BRK = 2'd3
    } parser_t;

endpackage

// File: rtl/key_target_decoder_if.sv
// Bus between the keyboard front end / game controller and the key target
// decoder.
// Handshake: scan_valid is a one-cycle strobe qualifying scan_code; there is
// no back-pressure, so every strobed byte is consumed on the rising edge it is
// sampled. fire is a level that stays high until the controller moves state
// to the wait code (shot taken) or away from the fire code (shot aborted).
interface key_target_decoder_if;
    import key_target_decoder_pkg::*;

    logic             scan_valid;
    logic [7:0]       scan_code;
    logic [2:0]       state;
    logic [CELLS-1:0] target_key;
    logic             fire;
    logic             sel_valid;
    logic             repeat_err;
    parser_t          parser_dbg;

    modport master (
        output scan_valid, scan_code, state,
        input  target_key, fire, sel_valid, repeat_err, parser_dbg
    );

    modport slave (
        input  scan_valid, scan_code, state,
        output target_key, fire, sel_valid, repeat_err, parser_dbg
    );

endinterface

// File: rtl/key_target_decoder_scancode_to_index.sv
// Combinational map from a PS/2 set-2 make code to a board cell index:
// letters A-Z -> 0-25, digits 0-9 -> 26-35. idx_ok is low for any other byte.
module scancode_to_index
    import key_target_decoder_pkg::*;
(
    input  logic [7:0] code,
    output logic [5:0] idx,
    output logic       idx_ok
);

    // Lookup of the 36 alphanumeric make codes
    always_comb begin
        idx    = 6'd0;
        idx_ok = 1'b1;
        case (code)
            8'h1C: idx = 6'd0;   // A
            8'h32: idx = 6'd1;   // B
            8'h21: idx = 6'd2;   // C
            8'h23: idx = 6'd3;   // D
            8'h24: idx = 6'd4;   // E
            8'h2B: idx = 6'd5;   // F
            8'h34: idx = 6'd6;   // G
            8'h33: idx = 6'd7;   // H
            8'h43: idx = 6'd8;   // I
            8'h3B: idx = 6'd9;   // J
            8'h42: idx = 6'd10;  // K
            8'h4B: idx = 6'd11;  // L
            8'h3A: idx = 6'd12;  // M
            8'h31: idx = 6'd13;  // N
            8'h44: idx = 6'd14;  // O
            8'h4D: idx = 6'd15;  // P
            8'h15: idx = 6'd16;  // Q
            8'h2D: idx = 6'd17;  // R
            8'h1B: idx = 6'd18;  // S
            8'h2C: idx = 6'd19;  // T
            8'h3C: idx = 6'd20;  // U
            8'h2A: idx = 6'd21;  // V
            8'h1D: idx = 6'd22;  // W
            8'h22: idx = 6'd23;  // X
            8'h35: idx = 6'd24;  // Y
            8'h1A: idx = 6'd25;  // Z
            8'h45: idx = 6'd26;  // 0
            8'h16: idx = 6'd27;  // 1
            8'h1E: idx = 6'd28;  // 2
            8'h26: idx = 6'd29;  // 3
            8'h25: idx = 6'd30;  // 4
            8'h2E: idx = 6'd31;  // 5
            8'h36: idx = 6'd32;  // 6
            8'h3D: idx = 6'd33;  // 7
            8'h3E: idx = 6'd34;  // 8
            8'h46: idx = 6'd35;  // 9
            default: idx_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/key_target_decoder.sv
// Key target decoder: parses PS/2 set-2 bytes into a one-hot board cell
// selection and raises a fire request on Enter.
// Optional feature macro: REPEAT_BLOCK_EN -- keeps a shot history and refuses
// (with a repeat_err pulse) to fire twice on the same cell.
module key_target_decoder
    import key_target_decoder_pkg::*;
#(
    parameter logic [2:0] FIRE_ST = ST_FIRE,
    parameter logic [2:0] WAIT_ST = ST_WAIT
) (
    input  logic                       clk,
    input  logic                       reset,
    key_target_decoder_if.slave        bus
);

    logic [5:0]       idx;
    logic             idx_ok;
    parser_t          pstate;
    logic [7:0]       held_code;
    logic [CELLS-1:0] target_key_q;
    logic             fire_q;
    logic             sel_valid_q;
    logic             in_fire_st;
    logic             make_act;
    logic             enter_sel;
    logic             already_hit;

    scancode_to_index u_map (
        .code   (bus.scan_code),
        .idx    (idx),
        .idx_ok (idx_ok)
    );

    assign in_fire_st = (bus.state == FIRE_ST);

    // A make byte that may change the selection: parser idle, not a prefix,
    // not an autorepeat of the held key, no shot pending, fire state active.
    assign make_act = bus.scan_valid && (pstate == P_IDLE) &&
                      (bus.scan_code != SC_BRK) && (bus.scan_code != SC_EXT) &&
                      (bus.scan_code != held_code) &&
                      !fire_q && in_fire_st;

    assign enter_sel = make_act && (bus.scan_code == SC_ENTER) && sel_valid_q;

`ifdef REPEAT_BLOCK_EN
    logic [CELLS-1:0] history_q;
    logic             repeat_err_q;

    assign already_hit    = |(history_q & target_key_q);
    assign bus.repeat_err = repeat_err_q;

    // Shot history: a cell is recorded only when its shot completes in WAIT_ST
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            history_q    <= '0;
            repeat_err_q <= 1'b0;
        end else begin
            repeat_err_q <= enter_sel && already_hit;
            if (fire_q && (bus.state == WAIT_ST))
                history_q <= history_q | target_key_q;
        end
    end
`else
    assign already_hit    = 1'b0;
    assign bus.repeat_err = 1'b0;
`endif

    // Parser FSM plus selection and fire registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pstate       <= P_IDLE;
            held_code    <= 8'h00;
            target_key_q <= '0;
            fire_q       <= 1'b0;
            sel_valid_q  <= 1'b0;
        end else begin
            if (bus.scan_valid) begin
                case (pstate)
                    P_IDLE: begin
                        if (bus.scan_code == SC_BRK)      pstate <= P_BRK;
                        else if (bus.scan_code == SC_EXT) pstate <= P_EXT;
                    end
                    P_BRK: begin
                        pstate <= P_IDLE;
                        if (bus.scan_code == held_code) held_code <= 8'h00;
                    end
                    P_EXT: begin
                        pstate <= (bus.scan_code == SC_BRK) ? P_EXT_BRK : P_IDLE;
                    end
                    default: pstate <= P_IDLE;
                endcase
            end

            // Leaving FIRE_ST with a shot pending ends it (WAIT) or aborts it;
            // either way the selection is dropped. History is handled above.
            if (fire_q && !in_fire_st) begin
                fire_q       <= 1'b0;
                target_key_q <= '0;
                sel_valid_q  <= 1'b0;
            end else if (make_act) begin
                if (idx_ok) begin
                    target_key_q <= {{(CELLS-1){1'b0}}, 1'b1} << idx;
                    sel_valid_q  <= 1'b1;
                    held_code    <= bus.scan_code;
                end else if (bus.scan_code == SC_BKSP) begin
                    target_key_q <= '0;
                    sel_valid_q  <= 1'b0;
                end else if (enter_sel && !already_hit) begin
                    fire_q <= 1'b1;
                end
            end
        end
    end

    assign bus.target_key = target_key_q;
    assign bus.fire       = fire_q;
    assign bus.sel_valid  = sel_valid_q;
    assign bus.parser_dbg = pstate;

endmodule

// File: tb/tb_key_target_decoder.sv
// Directed bench for key_target_decoder. Inputs change on the falling edge,
// outputs are checked on the following falling edge.
module tb_key_target_decoder;
    import key_target_decoder_pkg::*;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    key_target_decoder_if bus ();

    key_target_decoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One strobed byte; returns on the falling edge after it was consumed
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.scan_valid = 1'b1;
        bus.scan_code  = b;
        @(negedge clk);
        bus.scan_valid = 1'b0;
    endtask

    task automatic set_state(input logic [2:0] s);
        @(negedge clk);
        bus.state = s;
        @(negedge clk);
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        reset          = 1'b0;
        bus.scan_valid = 1'b0;
        bus.scan_code  = 8'h00;
        bus.state      = 3'd0;

        // Power-on reset
        repeat (2) @(negedge clk);
        check("rst_target", bus.target_key, 64'h0);
        check("rst_fire", bus.fire, 64'h0);
        check("rst_sel", bus.sel_valid, 64'h0);
        check("rst_rerr", bus.repeat_err, 64'h0);
        check("rst_parser", bus.parser_dbg, P_IDLE);
        @(negedge clk);
        reset = 1'b1;
        set_state(3'd3);

        // Basic select, break, fire, release
        send(8'h1C);
        check("t2_target_a", bus.target_key, 64'h1);
        check("t2_sel", bus.sel_valid, 64'h1);
        send(8'hF0);
        send(8'h1C);
        send(8'h5A);
        check("t2_fire", bus.fire, 64'h1);
        check("t2_target_hold", bus.target_key, 64'h1);
        set_state(3'd4);
        check("t2_fire_rel", bus.fire, 64'h0);
        check("t2_target_rel", bus.target_key, 64'h0);
        check("t2_sel_rel", bus.sel_valid, 64'h0);
        set_state(3'd3);

        // Autorepeat suppression
        send(8'h45);
        check("t3_digit0", bus.target_key, 64'h1 << 26);
        send(8'h45);
        send(8'h45);
        check("t3_repeat", bus.target_key, 64'h1 << 26);
        send(8'h66);
        check("t3_bksp", bus.target_key, 64'h0);
        send(8'h45);
        check("t3_held_ignored", bus.target_key, 64'h0);
        check("t3_held_sel", bus.sel_valid, 64'h0);
        send(8'hF0);
        send(8'h45);
        send(8'h16);
        check("t3_digit1", bus.target_key, 64'h1 << 27);
        send(8'hF0);
        send(8'h16);
        send(8'h66);

        // Repeat shot on the same cell
        send(8'h1A);
        check("t4_z", bus.target_key, 64'h1 << 25);
        send(8'hF0);
        send(8'h1A);
        send(8'h5A);
        check("t4_fire1", bus.fire, 64'h1);
        set_state(3'd4);
        check("t4_rel", bus.fire, 64'h0);
        set_state(3'd3);
        send(8'h1A);
        check("t4_z_again", bus.target_key, 64'h1 << 25);
        send(8'h5A);
`ifdef REPEAT_BLOCK_EN
        check("t4_rerr_pulse", bus.repeat_err, 64'h1);
        check("t4_no_fire", bus.fire, 64'h0);
        @(negedge clk);
        check("t4_rerr_end", bus.repeat_err, 64'h0);
        check("t4_still_no_fire", bus.fire, 64'h0);
`else
        check("t4_fire2", bus.fire, 64'h1);
        check("t4_rerr_tied", bus.repeat_err, 64'h0);
        set_state(3'd4);
        set_state(3'd3);
`endif
        send(8'h66);
        send(8'hF0);
        send(8'h1A);

        // Extended keys, Enter without selection, Backspace
        send(8'hE0);
        check("t5_parser_ext", bus.parser_dbg, P_EXT);
        send(8'h75);
        check("t5_arrow_target", bus.target_key, 64'h0);
        check("t5_parser_idle", bus.parser_dbg, P_IDLE);
        send(8'h5A);
        check("t5_enter_nosel", bus.fire, 64'h0);
        send(8'h1C);
        check("t5_a", bus.target_key, 64'h1);
        send(8'h66);
        check("t5_bksp_target", bus.target_key, 64'h0);
        check("t5_bksp_sel", bus.sel_valid, 64'h0);
        send(8'h5A);
        check("t5_enter_after_bksp", bus.fire, 64'h0);
        send(8'hF0);
        send(8'h1C);

        // Abort, frozen selection, release racing a byte
        send(8'h2B);
        check("t6_f", bus.target_key, 64'h1 << 5);
        send(8'h5A);
        check("t6_fire", bus.fire, 64'h1);
        send(8'hF0);
        send(8'h2B);
        send(8'h32);
        check("t6_frozen", bus.target_key, 64'h1 << 5);
        set_state(3'd1);
        check("t6_abort_fire", bus.fire, 64'h0);
        check("t6_abort_target", bus.target_key, 64'h0);
        set_state(3'd3);
        send(8'h2B);
        check("t6_f_again", bus.target_key, 64'h1 << 5);
        send(8'h5A);
        check("t6_refire", bus.fire, 64'h1);
        @(negedge clk);
        bus.state      = 3'd4;
        bus.scan_valid = 1'b1;
        bus.scan_code  = 8'h21;
        @(negedge clk);
        bus.scan_valid = 1'b0;
        check("t6_race_fire", bus.fire, 64'h0);
        check("t6_race_target", bus.target_key, 64'h0);
        check("t6_race_sel", bus.sel_valid, 64'h0);
        set_state(3'd3);
        send(8'h21);
        check("t6_c", bus.target_key, 64'h1 << 2);

        // Mid-game reset
        send(8'h5A);
        check("t1_fire_before", bus.fire, 64'h1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("t1_async_fire", bus.fire, 64'h0);
        check("t1_async_target", bus.target_key, 64'h0);
        check("t1_async_sel", bus.sel_valid, 64'h0);
        @(negedge clk);
        check("t1_in_rst_fire", bus.fire, 64'h0);
        reset = 1'b1;
        @(negedge clk);
        check("t1_after_fire", bus.fire, 64'h0);
        check("t1_after_target", bus.target_key, 64'h0);
        check("t1_after_rerr", bus.repeat_err, 64'h0);
        send(8'h1C);
        check("t1_a", bus.target_key, 64'h1);
        send(8'h5A);
        check("t1_hist_cleared", bus.fire, 64'h1);
        check("t1_no_rerr", bus.repeat_err, 64'h0);
        set_state(3'd4);
        check("t1_rel", bus.fire, 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
